// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and shared helpers for the VGA timing path.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  function automatic logic is_in_range(input int unsigned value,
                                       input int unsigned lo,
                                       input int unsigned hi_exclusive);
    return (value >= lo) && (value < hi_exclusive);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Enabled wrap counter over 0..MAX-1 with a combinational terminal-count flag.
module vga_axis_counter #(
  parameter int unsigned MAX = 800
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output int   count,
  output logic terminal
);

  assign terminal = (count == MAX - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 0;
    end else if (enable) begin
      count <= terminal ? 0 : count + 1;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster scan position, display enable and sync for the VGA output path.
// Optional VGA_TIMING_SYNC_DELAY_EN delays hsync/vsync by SYNC_DELAY enabled ticks.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT         = DEF_H_FRONT,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BACK          = DEF_H_BACK,
  parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT         = DEF_V_FRONT,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BACK          = DEF_V_BACK,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned SYNC_DELAY      = 2
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic pixel_enable,
  output logic hsync,
  output logic vsync,
  output int   row,
  output int   column,
  output logic display_enable,
  output logic line_start,
  output logic frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_LO   = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_HI   = HS_LO + H_SYNC;
  localparam int unsigned VS_LO   = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_HI   = VS_LO + V_SYNC;
  localparam logic        SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic        SYNC_OFF = ~SYNC_ON;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int unsigned SYNC_STAGES = SYNC_DELAY;
`else
  localparam int unsigned SYNC_STAGES = 0;
`endif

  int   h_cnt;
  int   v_cnt;
  logic h_term;
  logic v_term_unused;
  logic v_enable;
  logic hsync_base;
  logic vsync_base;

  assign v_enable = pixel_enable & h_term;

  vga_axis_counter #(
    .MAX(H_TOTAL)
  ) u_h_counter (
    .clk      (vga_clock),
    .reset    (reset),
    .enable   (pixel_enable),
    .count    (h_cnt),
    .terminal (h_term)
  );

  vga_axis_counter #(
    .MAX(V_TOTAL)
  ) u_v_counter (
    .clk      (vga_clock),
    .reset    (reset),
    .enable   (v_enable),
    .count    (v_cnt),
    .terminal (v_term_unused)
  );

  // Outputs reflect the pre-increment counters, so they lag the counters by one enabled tick.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      column         <= 0;
      row            <= 0;
      display_enable <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      hsync_base     <= SYNC_OFF;
      vsync_base     <= SYNC_OFF;
    end else if (pixel_enable) begin
      column         <= h_cnt;
      row            <= v_cnt;
      display_enable <= (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
      line_start     <= (h_cnt == 0);
      frame_start    <= (h_cnt == 0) && (v_cnt == 0);
      hsync_base     <= is_in_range(h_cnt, HS_LO, HS_HI) ? SYNC_ON : SYNC_OFF;
      vsync_base     <= is_in_range(v_cnt, VS_LO, VS_HI) ? SYNC_ON : SYNC_OFF;
    end else begin
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_sync_direct
      assign hsync = hsync_base;
      assign vsync = vsync_base;
    end else begin : g_sync_delay
      logic [SYNC_STAGES-1:0] hs_pipe;
      logic [SYNC_STAGES-1:0] vs_pipe;
      logic [SYNC_STAGES:0]   hs_chain;
      logic [SYNC_STAGES:0]   vs_chain;

      // Chain bit 0 is the undelayed sync; the top bit is the oldest stage.
      assign hs_chain = {hs_pipe, hsync_base};
      assign vs_chain = {vs_pipe, vsync_base};

      always_ff @(posedge vga_clock) begin
        if (reset) begin
          hs_pipe <= {SYNC_STAGES{SYNC_OFF}};
          vs_pipe <= {SYNC_STAGES{SYNC_OFF}};
        end else if (pixel_enable) begin
          hs_pipe <= hs_chain[SYNC_STAGES-1:0];
          vs_pipe <= vs_chain[SYNC_STAGES-1:0];
        end
      end

      assign hsync = hs_chain[SYNC_STAGES];
      assign vsync = vs_chain[SYNC_STAGES];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator using a reduced 30x17 raster so several frames fit in a short run.
module tb_vga_timing_generator;

  localparam int HV = 16;
  localparam int HF = 4;
  localparam int HSY = 6;
  localparam int HB = 4;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VV = 10;
  localparam int VF = 2;
  localparam int VSY = 2;
  localparam int VB = 3;
  localparam int VT = VV + VF + VSY + VB;
`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic vga_clock = 1'b0;
  logic reset;
  logic pixel_enable;
  logic hsync;
  logic vsync;
  int   row;
  int   column;
  logic display_enable;
  logic line_start;
  logic frame_start;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int t;
    int row;
    int col;
    int de;
    int hs;
    int vs;
    int ls;
    int fs;
  } vec_t;

  vec_t vecs[16];

  always #5 vga_clock = ~vga_clock;

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1), .SYNC_DELAY(2)
  ) dut (
    .vga_clock      (vga_clock),
    .reset          (reset),
    .pixel_enable   (pixel_enable),
    .hsync          (hsync),
    .vsync          (vsync),
    .row            (row),
    .column         (column),
    .display_enable (display_enable),
    .line_start     (line_start),
    .frame_start    (frame_start)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input logic rst, input logic en);
    reset = rst;
    pixel_enable = en;
    @(posedge vga_clock);
    #2;
  endtask

  // Expected active-low sync after enabled tick t (t=1 presents raster position 0).
  function automatic int exp_sync(input int t, input bit vert);
    int q;
    int v;
    q = t - 1 - SD;
    if (q < 0) return 1;
    if (vert) begin
      v = (q / HT) % VT;
      return (v >= VV + VF && v < VV + VF + VSY) ? 0 : 1;
    end
    v = q % HT;
    return (v >= HV + HF && v < HV + HF + HSY) ? 0 : 1;
  endfunction

  initial begin
    int p, ecol, erow;
    int pos_err, de_err, ls_err, sync_err, vs_row_err;
    int last_ls, last_fs, nfs;
    int in_hs, hs_first, hs_last, hs_len, hs_runs, vs_cnt;
    int e, tog_err, tog_last;

    //       t    row col de hs vs ls fs
    vecs[0]  = '{1,   0,  0, 1, 1, 1, 1, 1};
    vecs[1]  = '{2,   0,  1, 1, 1, 1, 0, 0};
    vecs[2]  = '{16,  0, 15, 1, 1, 1, 0, 0};
    vecs[3]  = '{17,  0, 16, 0, 1, 1, 0, 0};
    vecs[4]  = '{21,  0, 20, 0, 0, 1, 0, 0};
    vecs[5]  = '{26,  0, 25, 0, 0, 1, 0, 0};
    vecs[6]  = '{27,  0, 26, 0, 1, 1, 0, 0};
    vecs[7]  = '{30,  0, 29, 0, 1, 1, 0, 0};
    vecs[8]  = '{31,  1,  0, 1, 1, 1, 1, 0};
    vecs[9]  = '{301, 10, 0, 0, 1, 1, 1, 0};
    vecs[10] = '{360, 11, 29, 0, 1, 1, 0, 0};
    vecs[11] = '{361, 12, 0, 0, 1, 0, 1, 0};
    vecs[12] = '{420, 13, 29, 0, 1, 0, 0, 0};
    vecs[13] = '{421, 14, 0, 0, 1, 1, 1, 0};
    vecs[14] = '{510, 16, 29, 0, 1, 1, 0, 0};
    vecs[15] = '{511, 0,  0, 1, 1, 1, 1, 1};

    pos_err = 0; de_err = 0; ls_err = 0; sync_err = 0; vs_row_err = 0;
    last_ls = 0; last_fs = 0; nfs = 0;
    in_hs = 0; hs_first = 0; hs_last = 0; hs_len = 0; hs_runs = 0; vs_cnt = 0;

    reset = 1'b1;
    pixel_enable = 1'b1;
    repeat (3) @(posedge vga_clock);
    #2;
    chk("reset_row", row, 0);
    chk("reset_column", column, 0);
    chk("reset_de", display_enable, 0);
    chk("reset_hsync", hsync, 1);
    chk("reset_vsync", vsync, 1);
    chk("reset_line_start", line_start, 0);
    chk("reset_frame_start", frame_start, 0);

    for (int t = 1; t <= 1100; t++) begin
      tick(1'b0, 1'b1);
      p = t - 1;
      ecol = p % HT;
      erow = (p / HT) % VT;
      if (column != ecol || row != erow) pos_err++;
      if (int'(display_enable) != int'(ecol < HV && erow < VV)) de_err++;
      if (int'(line_start) != int'(ecol == 0)) ls_err++;
      if (int'(hsync) != exp_sync(t, 1'b0) || int'(vsync) != exp_sync(t, 1'b1)) sync_err++;

      for (int i = 0; i < 16; i++) begin
        if (vecs[i].t == t) begin
          chk($sformatf("vec%0d_row", i), row, vecs[i].row);
          chk($sformatf("vec%0d_column", i), column, vecs[i].col);
          chk($sformatf("vec%0d_de", i), display_enable, vecs[i].de);
          chk($sformatf("vec%0d_line_start", i), line_start, vecs[i].ls);
          chk($sformatf("vec%0d_frame_start", i), frame_start, vecs[i].fs);
`ifdef VGA_TIMING_SYNC_DELAY_EN
          chk($sformatf("vec%0d_hsync", i), hsync, exp_sync(t, 1'b0));
          chk($sformatf("vec%0d_vsync", i), vsync, exp_sync(t, 1'b1));
`else
          chk($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
          chk($sformatf("vec%0d_vsync", i), vsync, vecs[i].vs);
`endif
        end
      end

      if (line_start) begin
        if (last_ls > 0) chk("line_start_period", t - last_ls, HT);
        last_ls = t;
      end
      if (frame_start) begin
        if (last_fs > 0) begin
          chk("frame_start_period", t - last_fs, HT * VT);
          chk("vsync_ticks_per_frame", vs_cnt, VSY * HT);
        end
        last_fs = t;
        nfs++;
        vs_cnt = 0;
      end

      if (!hsync) begin
        if (in_hs == 0) begin
          in_hs = 1;
          hs_first = column;
          hs_len = 0;
        end
        hs_len++;
        hs_last = column;
      end else if (in_hs != 0) begin
        in_hs = 0;
        hs_runs++;
        chk("hsync_first_col", hs_first, HV + HF + SD);
        chk("hsync_len", hs_len, HSY);
        chk("hsync_last_col", hs_last, HV + HF + HSY - 1 + SD);
      end

      if (!vsync) begin
        vs_cnt++;
        if (row < VV + VF || row > VV + VF + VSY - 1 + ((SD > 0) ? 1 : 0)) vs_row_err++;
      end
    end
    chk("scan_position_errors", pos_err, 0);
    chk("scan_de_errors", de_err, 0);
    chk("scan_line_start_errors", ls_err, 0);
    chk("scan_sync_errors", sync_err, 0);
    chk("vsync_row_errors", vs_row_err, 0);
    chk("frame_start_count", nfs, 3);
    chk("hsync_run_count", hs_runs, 36);

    // pixel_enable alternating 1,0,1,0: hold on disabled cycles, single-cycle pulses.
    tick(1'b1, 1'b1);
    e = 0; tog_err = 0; tog_last = -1;
    for (int c = 0; c < 400; c++) begin
      tick(1'b0, (c % 2) == 0);
      if ((c % 2) == 0) e++;
      p = e - 1;
      ecol = p % HT;
      erow = (p / HT) % VT;
      if (column != ecol || row != erow) tog_err++;
      if (int'(display_enable) != int'(ecol < HV && erow < VV)) tog_err++;
      if (int'(hsync) != exp_sync(e, 1'b0) || int'(vsync) != exp_sync(e, 1'b1)) tog_err++;
      if (int'(line_start) != int'((c % 2) == 0 && ecol == 0)) tog_err++;
      if (int'(frame_start) != int'((c % 2) == 0 && p == 0)) tog_err++;
      if (line_start) begin
        if (tog_last >= 0) chk("toggle_line_start_period", c - tog_last, 2 * HT);
        tog_last = c;
      end
    end
    chk("toggle_errors", tog_err, 0);

    // Mid-frame reset with pixel_enable low: reset must win over the hold.
    tick(1'b1, 1'b1);
    for (int t = 1; t <= 158; t++) tick(1'b0, 1'b1);
    chk("pre_reset_row", row, 5);
    chk("pre_reset_column", column, 7);
    chk("pre_reset_de", display_enable, 1);
    tick(1'b1, 1'b0);
    chk("midreset_row", row, 0);
    chk("midreset_column", column, 0);
    chk("midreset_de", display_enable, 0);
    chk("midreset_hsync", hsync, 1);
    chk("midreset_vsync", vsync, 1);
    chk("midreset_frame_start", frame_start, 0);
    tick(1'b0, 1'b1);
    chk("restart_row", row, 0);
    chk("restart_column", column, 0);
    chk("restart_de", display_enable, 1);
    chk("restart_line_start", line_start, 1);
    chk("restart_frame_start", frame_start, 1);
    tick(1'b0, 1'b0);
    chk("restart_pulse_width", frame_start, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Produces raster scan position and sync for the VGA output path: hsync, vsync, row, column and display_enable.
It is the source end of the row/column/display_enable interface consumed by the screen drawers and VgaInterface.
The drawers use that position to render pixels.
Default timing is 640x480@60 with one pixel per enabled vga_clock tick.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses driven 0 when asserted
SYNC_DELAY, 2, extra pipeline stages on hsync/vsync (used only with the optional feature)

Ports:
vga_clock  input  1  pixel clock domain; everything is synchronous to it
reset  input  1  synchronous, active-high reset
pixel_enable  input  1  clock enable; scan advances only on cycles where this is 1
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
row  output  int  current line, 0..V_TOTAL-1
column  output  int  current pixel, 0..H_TOTAL-1
display_enable  output  1  1 iff column<H_VISIBLE and row<V_VISIBLE
line_start  output  1  one-cycle pulse when column==0 is presented
frame_start  output  1  one-cycle pulse when row==0 and column==0 are presented

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Internal counters: h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
- Reset, checked on every edge and taking priority over pixel_enable:
  - h_cnt=0, v_cnt=0, row=0, column=0.
  - display_enable=0, line_start=0, frame_start=0.
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1).
- Enabled tick (pixel_enable=1, reset=0): all outputs are registered from the pre-increment counter values. Latency is one enabled tick.
  - column<=h_cnt; row<=v_cnt.
  - display_enable<=(h_cnt<H_VISIBLE)&&(v_cnt<V_VISIBLE).
  - hsync asserted iff h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752).
  - vsync asserted iff v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492). vsync therefore changes on the column-0 tick.
  - line_start<=(h_cnt==0); frame_start<=(h_cnt==0 && v_cnt==0).
  - Counter update:
    - h_cnt==H_TOTAL-1: h_cnt<=0, and v_cnt advances.
    - v_cnt advance: v_cnt==V_TOTAL-1 -> v_cnt<=0, otherwise v_cnt+1.
    - otherwise: h_cnt+1.
- Disabled tick (pixel_enable=0): counters and row, column, display_enable, hsync, vsync hold. line_start and frame_start are forced to 0, so each pulse lasts exactly one vga_clock cycle.
- First enabled tick after reset release presents (0,0), display_enable=1, line_start=1, frame_start=1.
- Reset mid-frame: the next cycle shows reset values; the following enabled tick restarts at (0,0) with frame_start=1. No partial-frame recovery.
- Counter widths: declared int to match the consumer interface. Comparisons are unsigned in range; no overflow is possible.

Optional Feature:
- Macro: VGA_TIMING_SYNC_DELAY_EN.
- When defined:
  - hsync and vsync each pass through an SYNC_DELAY-deep shift register, advanced only on enabled ticks. This aligns sync with a renderer of SYNC_DELAY pipeline stages.
  - Shift registers reset to the inactive level.
  - row, column, display_enable, line_start and frame_start are not delayed.
- When undefined: SYNC_DELAY is ignored and sync has the base one-tick latency.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480 timing constants (H_*/V_* values, H_TOTAL, V_TOTAL);
  - the function is_in_range(value, lo, hi_exclusive).
- One sub-module, vga_axis_counter: a wrap counter with enable, terminal-count output and parameter MAX.
  - Instantiated twice. The horizontal instance is enabled by pixel_enable.
  - The vertical instance is enabled by pixel_enable AND the horizontal terminal count.

Test Plan:
- reset 3 cycles, then pixel_enable=1 continuously:
  - first enabled tick gives row=0, column=0, display_enable=1, frame_start=1;
  - line_start pulses every 800 cycles;
  - frame_start pulses every 420000 cycles.
- Same run, horizontal sync: hsync=0 for exactly 96 consecutive ticks, first with column=656, last with column=751; display_enable=0 for columns 640..799.
- Same run, vertical sync: vsync=0 for exactly 1600 ticks covering rows 490..491; display_enable=0 for all of rows 480..524.
- pixel_enable toggling 1,0,1,0:
  - outputs hold on disabled cycles;
  - line_start period becomes 1600 cycles, and each pulse is 1 cycle wide.
- reset asserted for 1 cycle at row=300, column=123: next cycle gives row=0, column=0, display_enable=0, hsync=vsync=1; the following enabled tick gives frame_start=1.
- With VGA_TIMING_SYNC_DELAY_EN and SYNC_DELAY=2: hsync falls on the tick where column=658 is presented, and stays low for 96 ticks.
